// File: rtl/decode_stage_pkg.sv
// ----------------------------------------------------------------------------
// simplecore_pkg
// Shared SimpleCore decode definitions: instruction class encoding, the
// "always" branch condition and the five-bit opcode patterns that mark the
// compare, MSR and MRS/exit instructions.
// No ports (package).
// ----------------------------------------------------------------------------
package simplecore_pkg;

    typedef enum logic [2:0] {
        INST_ALUI   = 3'd0,
        INST_ALUR   = 3'd1,
        INST_SHRO   = 3'd2,
        INST_LOAD   = 3'd3,
        INST_STORE  = 3'd4,
        INST_BRANCH = 3'd5,
        INST_MUL    = 3'd6
    } inst_id_e;

    localparam logic [1:0] COND_AL = 2'b11;

    // Patterns matched against inst[15:11]
    localparam logic [4:0] OP_CMP      = 5'b00101;
    localparam logic [4:0] OP_MSR      = 5'b00110;
    localparam logic [4:0] OP_MRS_EXIT = 5'b00111;

endpackage

// File: rtl/decode_stage_if.sv
// ----------------------------------------------------------------------------
// decode_stage_if
// Fetch-side and execute-side signals of the decode stage, bundled together.
//   master : the surrounding pipeline (drives fetch inputs, flush, dReady)
//   slave  : the decode stage (drives fReady, dValid, status and fields)
// Parameters: DATA_W (immediate width), RIDX_W (register index width).
// ----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int RIDX_W = 4
);
    logic              fValid;
    logic [15:0]       fInst;
    logic              fReady;
    logic              flush;
    logic              dValid;
    logic              dReady;
    logic              refill;
    logic              halted;
    logic [2:0]        instId;
    logic [1:0]        cond;
    logic [2:0]        opcode;
    logic [1:0]        shift;
    logic [RIDX_W-1:0] rs1Idx;
    logic [RIDX_W-1:0] rs2Idx;
    logic [RIDX_W-1:0] rdIdx;
    logic [DATA_W-1:0] imm;
    logic              immFlag;
    logic              cmpFlag;
    logic              branchFlag;
    logic              exitFlag;
    logic              srOEn;
    logic              srWbEn;

    modport master (
        output fValid, fInst, flush, dReady,
        input  fReady, dValid, refill, halted, instId, cond, opcode, shift,
               rs1Idx, rs2Idx, rdIdx, imm, immFlag, cmpFlag, branchFlag,
               exitFlag, srOEn, srWbEn
    );

    modport slave (
        input  fValid, fInst, flush, dReady,
        output fReady, dValid, refill, halted, instId, cond, opcode, shift,
               rs1Idx, rs2Idx, rdIdx, imm, immFlag, cmpFlag, branchFlag,
               exitFlag, srOEn, srWbEn
    );
endinterface

// File: rtl/decode_stage_fields.sv
// ----------------------------------------------------------------------------
// decode_fields
// Purely combinational classifier and field extractor for one 16-bit
// SimpleCore instruction.
//   inst                      : raw instruction
//   inst_id, cond             : class and branch condition (COND_AL if not branch)
//   opcode, shift             : inst[13:11], inst[12:11]
//   rs1_idx, rs2_idx, rd_idx  : register indices, zero-extended to RIDX_W
//   imm                       : branch offset (sign-ext) or inst[6:0] (zero-ext)
//   *_flag, sr_oen, sr_wb_en  : decode flags
// ----------------------------------------------------------------------------
module decode_fields
    import simplecore_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RIDX_W = 4
) (
    input  logic [15:0]       inst,
    output inst_id_e          inst_id,
    output logic [1:0]        cond,
    output logic [2:0]        opcode,
    output logic [1:0]        shift,
    output logic [RIDX_W-1:0] rs1_idx,
    output logic [RIDX_W-1:0] rs2_idx,
    output logic [RIDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0] imm,
    output logic              imm_flag,
    output logic              cmp_flag,
    output logic              branch_flag,
    output logic              exit_flag,
    output logic              sr_oen,
    output logic              sr_wb_en
);
    logic       is_branch;
    logic [4:0] top5;

    always_comb begin
        inst_id = INST_BRANCH;
        casez (inst[15:12])
            4'b00??: inst_id = INST_ALUI;
            4'b01??: inst_id = INST_ALUR;
            4'b100?: inst_id = INST_SHRO;
            4'b1010: inst_id = INST_LOAD;
            4'b1011: inst_id = INST_STORE;
            4'b1111: inst_id = INST_MUL;
            default: inst_id = INST_BRANCH;
        endcase
    end

    assign top5      = inst[15:11];
    assign is_branch = (inst_id == INST_BRANCH);

    assign cond    = is_branch ? inst[13:12] : COND_AL;
    assign opcode  = inst[13:11];
    assign shift   = inst[12:11];
    assign rs1_idx = RIDX_W'(inst[3:0]);
    assign rs2_idx = RIDX_W'(inst[6:4]);
    assign rd_idx  = RIDX_W'(inst[10:7]);

    // Branch offsets are 12-bit two's complement; everything else uses a
    // small unsigned 7-bit immediate.
    assign imm = is_branch ? {{(DATA_W-12){inst[11]}}, inst[11:0]}
                           : DATA_W'(inst[6:0]);

    assign imm_flag    = (inst_id == INST_ALUI);
    assign branch_flag = is_branch;
    assign cmp_flag    = (top5 == OP_CMP);
    assign exit_flag   = (top5 == OP_MRS_EXIT);
    assign sr_oen      = (top5 == OP_MRS_EXIT);
    assign sr_wb_en    = (top5 == OP_MSR) || (top5 == OP_CMP);
endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Registered decode stage between fetch and execute. Decodes the fetched
// instruction combinationally, then holds decoded bundles in a main entry
// (which drives the outputs) and a skid entry. Handles flush/refill bubbles
// and latches a halt once an exit instruction is taken by execute.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : decode_stage_if.slave (fetch handshake, flush, execute handshake,
//           refill/halted status and decoded fields)
// Parameters: DATA_W, RIDX_W, REFILL_CYC (1..15).
// ----------------------------------------------------------------------------
module decode_stage
    import simplecore_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RIDX_W     = 4,
    parameter int REFILL_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam int              CNT_W       = 4;
    localparam logic [CNT_W-1:0] REFILL_LOAD = CNT_W'(REFILL_CYC);

    typedef struct packed {
        inst_id_e          inst_id;
        logic [1:0]        cond;
        logic [2:0]        opcode;
        logic [1:0]        shift;
        logic [RIDX_W-1:0] rs1_idx;
        logic [RIDX_W-1:0] rs2_idx;
        logic [RIDX_W-1:0] rd_idx;
        logic [DATA_W-1:0] imm;
        logic              imm_flag;
        logic              cmp_flag;
        logic              branch_flag;
        logic              exit_flag;
        logic              sr_oen;
        logic              sr_wb_en;
    } bundle_t;

    bundle_t          dec;
    bundle_t          main_q;
    bundle_t          skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] cnt;
    logic             halted;
    logic             f_ready_r;

    logic accept;
    logic refill_act;
    logic drain;
    logic halt_now;
    logic main_free;
    logic push;
    logic halted_nx;
    logic main_valid_nx;
    logic skid_valid_nx;
    logic main_from_skid;
    logic main_from_in;
    logic skid_from_in;

    decode_fields #(
        .DATA_W (DATA_W),
        .RIDX_W (RIDX_W)
    ) u_fields (
        .inst        (bus.fInst),
        .inst_id     (dec.inst_id),
        .cond        (dec.cond),
        .opcode      (dec.opcode),
        .shift       (dec.shift),
        .rs1_idx     (dec.rs1_idx),
        .rs2_idx     (dec.rs2_idx),
        .rd_idx      (dec.rd_idx),
        .imm         (dec.imm),
        .imm_flag    (dec.imm_flag),
        .cmp_flag    (dec.cmp_flag),
        .branch_flag (dec.branch_flag),
        .exit_flag   (dec.exit_flag),
        .sr_oen      (dec.sr_oen),
        .sr_wb_en    (dec.sr_wb_en)
    );

    assign accept     = bus.fValid & f_ready_r;
    assign refill_act = (cnt != '0);
    assign drain      = main_valid & bus.dReady;
    assign halt_now   = drain & main_q.exit_flag;
    assign main_free  = ~main_valid | drain;
    // Instructions taken during the refill window are swallowed here.
    assign push       = accept & ~refill_act;

    always_comb begin
        halted_nx      = halted | halt_now;
        main_valid_nx  = main_valid;
        skid_valid_nx  = skid_valid;
        main_from_skid = 1'b0;
        main_from_in   = 1'b0;
        skid_from_in   = 1'b0;
        if (bus.flush || halted_nx) begin
            main_valid_nx = 1'b0;
            skid_valid_nx = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // fReady is low while skid is occupied, so no push can race this
                main_from_skid = 1'b1;
                main_valid_nx  = 1'b1;
                skid_valid_nx  = 1'b0;
            end else if (push) begin
                main_from_in  = 1'b1;
                main_valid_nx = 1'b1;
            end else begin
                main_valid_nx = 1'b0;
            end
        end else if (push) begin
            skid_from_in  = 1'b1;
            skid_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            main_q      <= '0;
            main_q.cond <= COND_AL;
            skid_q      <= '0;
            skid_q.cond <= COND_AL;
            cnt         <= REFILL_LOAD;
            halted      <= 1'b0;
            f_ready_r   <= 1'b0;
        end else begin
            main_valid <= main_valid_nx;
            skid_valid <= skid_valid_nx;
            if (main_from_skid) begin
                main_q <= skid_q;
            end else if (main_from_in) begin
                main_q <= dec;
            end
            if (skid_from_in) begin
                skid_q <= dec;
            end
            halted <= halted_nx;
            if (bus.flush) begin
                cnt <= REFILL_LOAD;
            end else if (refill_act) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Computed from next state so fReady drops in the same cycle the
            // skid entry becomes occupied and can never admit an overflow.
            f_ready_r <= ~skid_valid_nx & ~halted_nx;
        end
    end

    assign bus.fReady     = f_ready_r;
    assign bus.dValid     = main_valid;
    assign bus.refill     = refill_act;
    assign bus.halted     = halted;
    assign bus.instId     = main_q.inst_id;
    assign bus.cond       = main_q.cond;
    assign bus.opcode     = main_q.opcode;
    assign bus.shift      = main_q.shift;
    assign bus.rs1Idx     = main_q.rs1_idx;
    assign bus.rs2Idx     = main_q.rs2_idx;
    assign bus.rdIdx      = main_q.rd_idx;
    assign bus.imm        = main_q.imm;
    assign bus.immFlag    = main_q.imm_flag;
    assign bus.cmpFlag    = main_q.cmp_flag;
    assign bus.branchFlag = main_q.branch_flag;
    assign bus.exitFlag   = main_q.exit_flag;
    assign bus.srOEn      = main_q.sr_oen;
    assign bus.srWbEn     = main_q.sr_wb_en;
endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Scoreboarded bench for decode_stage: a reference model computes the decoded
// bundle of every instruction that should reach execute and queues it; a
// monitor pops and compares whenever execute takes a bundle.
// ----------------------------------------------------------------------------
module tb_decode_stage;
    localparam int DATA_W     = 32;
    localparam int RIDX_W     = 5;
    localparam int REFILL_CYC = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(DATA_W), .RIDX_W(RIDX_W)) bus();

    decode_stage #(
        .DATA_W     (DATA_W),
        .RIDX_W     (RIDX_W),
        .REFILL_CYC (REFILL_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [2:0]        inst_id;
        logic [1:0]        cond;
        logic [2:0]        opcode;
        logic [1:0]        shift;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic [RIDX_W-1:0] rd;
        logic [DATA_W-1:0] imm;
        logic              imm_f;
        logic              cmp_f;
        logic              br_f;
        logic              exit_f;
        logic              sro_f;
        logic              srwb_f;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   ref_cnt  = REFILL_CYC;
    bit   m_halted = 1'b0;
    bit   exit_consumed = 1'b0;

    // Reference decode, straight from the instruction-set rules.
    function automatic exp_t model_decode(logic [15:0] i);
        exp_t e;
        int   hi   = int'(i[15:12]);
        int   top5 = int'(i[15:11]);
        int   off;
        e = '0;
        if (hi < 4)        e.inst_id = 3'd0;
        else if (hi < 8)   e.inst_id = 3'd1;
        else if (hi < 10)  e.inst_id = 3'd2;
        else if (hi == 10) e.inst_id = 3'd3;
        else if (hi == 11) e.inst_id = 3'd4;
        else if (hi < 15)  e.inst_id = 3'd5;
        else               e.inst_id = 3'd6;
        if (e.inst_id == 3'd5) begin
            e.cond = i[13:12];
            off = int'(i[11:0]);
            if (off >= 2048) off = off - 4096;
            e.imm  = DATA_W'(off);
            e.br_f = 1'b1;
        end else begin
            e.cond = 2'b11;
            e.imm  = DATA_W'(int'(i[6:0]));
        end
        e.opcode = i[13:11];
        e.shift  = i[12:11];
        e.rs1    = RIDX_W'(int'(i[3:0]));
        e.rs2    = RIDX_W'(int'(i[6:4]));
        e.rd     = RIDX_W'(int'(i[10:7]));
        e.imm_f  = (e.inst_id == 3'd0);
        e.cmp_f  = (top5 == 5);
        e.exit_f = (top5 == 7);
        e.sro_f  = (top5 == 7);
        e.srwb_f = (top5 == 5) || (top5 == 6);
        return e;
    endfunction

    function automatic logic [15:0] rand_inst();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[15:11] == 5'b00111) v[11] = 1'b0;
        return v;
    endfunction

    // Monitor: compare every bundle execute takes.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        exit_consumed = 1'b0;
        if (!reset && bus.dValid && bus.dReady) begin
            got = {bus.instId, bus.cond, bus.opcode, bus.shift, bus.rs1Idx,
                   bus.rs2Idx, bus.rdIdx, bus.imm, bus.immFlag, bus.cmpFlag,
                   bus.branchFlag, bus.exitFlag, bus.srOEn, bus.srWbEn};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_bundle got=%h expected=none", got);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL bundle got=%h expected=%h", got, want);
                end
                exit_consumed = want.exit_f;
            end
        end
    end

    // Model of what the coming clock edge does: queue/drop/flush/halt/refill.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            sb_q.delete();
            ref_cnt  = REFILL_CYC;
            m_halted = 1'b0;
        end else begin
            checks++;
            if (bus.refill !== (ref_cnt != 0)) begin
                failures++;
                $display("FAIL refill got=%0b expected=%0b", bus.refill, (ref_cnt != 0));
            end
            checks++;
            if (bus.halted !== m_halted) begin
                failures++;
                $display("FAIL halted got=%0b expected=%0b", bus.halted, m_halted);
            end
            if (m_halted) begin
                checks++;
                if (bus.fReady !== 1'b0) begin
                    failures++;
                    $display("FAIL fready_halted got=%0b expected=0", bus.fReady);
                end
            end
            if (exit_consumed) begin
                m_halted = 1'b1;
                sb_q.delete();
            end else if (bus.flush) begin
                sb_q.delete();
            end else if (bus.fValid && bus.fReady && ref_cnt == 0 && !m_halted) begin
                sb_q.push_back(model_decode(bus.fInst));
            end
            if (bus.flush) ref_cnt = REFILL_CYC;
            else if (ref_cnt > 0) ref_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic wait_refill_done();
        for (int k = 0; k < 20; k++) begin
            if (!bus.refill) return;
            tick();
        end
        checks++;
        failures++;
        $display("FAIL refill_timeout got=1 expected=0");
    endtask

    task automatic wait_halted();
        for (int k = 0; k < 20; k++) begin
            if (bus.halted) return;
            tick();
        end
        checks++;
        failures++;
        $display("FAIL halt_timeout got=0 expected=1");
    endtask

    task automatic drain(input int n);
        bus.fValid = 1'b0;
        bus.dReady = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        bus.fValid = 1'b0;
        bus.fInst  = '0;
        bus.flush  = 1'b0;
        bus.dReady = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dvalid", 64'(bus.dValid), 0);
        check("rst_refill", 64'(bus.refill), 1);
        check("rst_halted", 64'(bus.halted), 0);
        check("rst_fready", 64'(bus.fReady), 0);
        check("rst_cond",   64'(bus.cond), 3);
        check("rst_instid", 64'(bus.instId), 0);
        check("rst_imm",    64'(bus.imm), 0);
        reset = 1'b0;
        tick();
        check("fready_after_release", 64'(bus.fReady), 1);
        wait_refill_done();

        // Back-to-back stream, one per cycle
        bus.dReady = 1'b1;
        bus.fValid = 1'b1;
        bus.fInst  = 16'h1083;
        tick();
        check("alui_id",  64'(bus.instId), 0);
        check("alui_imm", 64'(bus.imm), 3);
        bus.fInst = 16'h4123;
        tick();
        check("alur_id", 64'(bus.instId), 1);
        bus.fInst = 16'hCFFE;
        tick();
        check("br_id",   64'(bus.instId), 5);
        check("br_cond", 64'(bus.cond), 0);
        check("br_imm",  64'(bus.imm), 64'hFFFF_FFFE);
        check("br_flag", 64'(bus.branchFlag), 1);
        bus.fValid = 1'b0;
        tick();
        check("stream_idle_dvalid", 64'(bus.dValid), 0);

        // Stall: main then skid fill, fReady drops, nothing lost
        bus.dReady = 1'b0;
        bus.fValid = 1'b1;
        bus.fInst  = 16'h5A21;
        tick();
        bus.fInst = 16'h9C44;
        tick();
        check("stall_fready", 64'(bus.fReady), 0);
        check("stall_dvalid", 64'(bus.dValid), 1);
        check("stall_hold_id", 64'(bus.instId), 1);
        bus.fInst = 16'h2222;
        tick();
        check("stall_fready2", 64'(bus.fReady), 0);
        check("stall_hold_id2", 64'(bus.instId), 1);
        bus.dReady = 1'b1;
        bus.fValid = 1'b0;
        repeat (3) tick();

        // Flush with both entries full
        bus.dReady = 1'b0;
        bus.fValid = 1'b1;
        bus.fInst  = 16'hA123;
        tick();
        bus.fInst = 16'hB456;
        tick();
        bus.flush = 1'b1;
        bus.fInst = 16'h7777;
        tick();
        bus.flush = 1'b0;
        check("flush_dvalid", 64'(bus.dValid), 0);
        check("flush_refill", 64'(bus.refill), 1);
        bus.dReady = 1'b1;
        for (int n = 0; n < 6; n++) begin
            bus.fInst = rand_inst();
            tick();
        end
        drain(6);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.fValid = ($urandom_range(0, 3) != 0);
            bus.fInst  = rand_inst();
            bus.dReady = ($urandom_range(0, 3) != 0);
            bus.flush  = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.flush = 1'b0;
        drain(8);
        check("queue_empty_random", 64'(sb_q.size()), 0);
        wait_refill_done();

        // Exit instruction halts the stage
        bus.dReady = 1'b1;
        bus.fValid = 1'b1;
        bus.fInst  = 16'h3800;
        tick();
        bus.fInst = 16'h1083;
        wait_halted();
        check("halted_set", 64'(bus.halted), 1);
        repeat (3) tick();
        check("halt_fready", 64'(bus.fReady), 0);
        check("halt_dvalid", 64'(bus.dValid), 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        check("halt_after_flush", 64'(bus.halted), 1);
        bus.fValid = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_clears_halt", 64'(bus.halted), 0);
        tick();
        reset = 1'b0;
        wait_refill_done();

        // Asynchronous reset mid-stream
        bus.dReady = 1'b0;
        bus.fValid = 1'b1;
        bus.fInst  = 16'h1234;
        tick();
        check("pre_areset_dvalid", 64'(bus.dValid), 1);
        #2 reset = 1'b1;
        #1;
        check("areset_dvalid", 64'(bus.dValid), 0);
        check("areset_refill", 64'(bus.refill), 1);
        check("areset_fready", 64'(bus.fReady), 0);
        check("areset_cond",   64'(bus.cond), 3);
        tick();
        reset = 1'b0;
        bus.fValid = 1'b0;
        tick();
        wait_refill_done();
        bus.dReady = 1'b1;
        bus.fValid = 1'b1;
        bus.fInst  = 16'hF0A5;
        tick();
        check("post_reset_id", 64'(bus.instId), 6);
        drain(4);
        check("queue_empty_final", 64'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for SimpleCore. It sits between fetch and execute. It classifies each 16-bit instruction, extracts its fields, and presents them through a valid/ready handshake backed by a 2-entry skid buffer. It also manages flush/refill bubbles with a programmable refill length and latches a halt after an exit instruction retires.

## Interface
- DATA_W, 16, immediate/data width (≥16)
- RIDX_W, 4, register index width (≥4; indices zero-extended)
- REFILL_CYC, 2, cycles of refill after reset/flush (1..15)

- clk  in  1  main clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fValid  in  1  fetch instruction valid
- fInst  in  16  fetched instruction
- fReady  out  1  stage can accept (registered)
- flush  in  1  pipeline flush, one-cycle pulse
- dValid  out  1  decoded bundle valid
- dReady  in  1  execute accepts bundle
- refill  out  1  refill window active
- halted  out  1  exit instruction retired; stage frozen
- instId  out  3  instruction class
- cond  out  2  branch condition
- opcode  out  3  fInst[13:11]
- shift  out  2  fInst[12:11]
- rs1Idx, rs2Idx, rdIdx  out  RIDX_W each  fInst[3:0], {0,fInst[6:4]}, fInst[10:7], zero-extended
- imm  out  DATA_W  immediate
- immFlag, cmpFlag, branchFlag, exitFlag, srOEn, srWbEn  out  1 each  decode flags

## Operation
- Class from fInst[15:12]: 00xx ALUI, 01xx ALUR, 100x SHRO, 1010 LOAD, 1011 STORE, 1100/1101/1110 BRANCH, 1111 MUL.
- cond = fInst[13:12] for BRANCH, else COND_AL.
- imm:
  - BRANCH: fInst[11:0] sign-extended to DATA_W.
  - Otherwise: fInst[6:0] zero-extended.
- immFlag = ALUI; branchFlag = BRANCH.
- cmpFlag = fInst[15:11]==00101; exitFlag = srOEn = fInst[15:11]==00111; srWbEn = 00110 or 00101.
- Decode is combinational on input. The decoded bundle is what gets stored in the skid entries.
- Entries: main (drives outputs) and skid.
  - Accept when fValid&fReady.
  - An accepted bundle goes to main if main is empty or draining this cycle, else to skid.
  - fReady = !skidValid & !halted, registered.
- Refill counter: loaded with REFILL_CYC on reset or flush, decrements each cycle to 0.
  - refill = counter≠0.
  - Instructions accepted while refill=1 are consumed and dropped, never reaching dValid.
- Flush: both entries invalidated next cycle, counter reloaded, any same-cycle input dropped.
- Halt: when dValid&dReady with exitFlag, halted sets and stays set until reset. Once halted:
  - fReady=0.
  - Remaining entries are invalidated.
  - Flush does not clear halted.

## Timing
- Reset values: dValid=0, fReady=0 during reset, then 1 on the first cycle after release; refill=1; halted=0; counter=REFILL_CYC; all field outputs 0, cond=COND_AL.
- Latency: 1 cycle from fValid&fReady to dValid when main is empty or draining.
- Throughput: 1 per cycle while dReady=1.
- Outputs hold stable while dValid&!dReady.
- Skid full: fReady drops the cycle after the skid entry fills, and returns the cycle after the skid drains into main.
- Flush together with dReady: the bundle in main is still consumed by execute that cycle; state clears after.
- Flush has priority over accept, refill decrement and skid moves.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

## Structure
- simplecore_pkg holds:
  - INST_ALUI=0, INST_ALUR=1, INST_SHRO=2, INST_LOAD=3, INST_STORE=4, INST_BRANCH=5, INST_MUL=6
  - COND_AL=2'b11
  - opcode pattern constants CMP=00101, MSR=00110, MRS_EXIT=00111
- Sub-module decode_fields: purely combinational classifier/field extractor parametrised by DATA_W and RIDX_W.
- decode_stage holds the skid logic, refill counter and halt latch.

## Test plan
- Reset, then stream 0x1083 (ALUI), 0x4123 (ALUR) with dReady=1 after refill ends -> instIds 0 then 1, one per cycle, imm=0x0003 on the first.
- Branch 0xCFFE with DATA_W=32 -> instId=5, cond=00, imm=0xFFFFFFFE, branchFlag=1.
- dReady=0 for 3 cycles while fValid=1 -> two bundles held, fReady=0 from the third cycle, no loss or duplication after dReady returns.
- Flush pulse with both entries full and REFILL_CYC=3 -> dValid=0 next cycle, refill high 3 cycles, instructions fetched during refill never appear.
- Exit 0x3800 accepted by execute -> halted=1, fReady=0 permanently, a later flush leaves halted=1, and reset clears it.
- Reset asserted asynchronously mid-stream -> dValid=0, refill=1 without waiting for a clock edge.
